// File: rtl/nrisc_pkg.sv
// Shared definitions for the NRISC execute path: default widths, ULA op
// codes and flag bit positions.
package nrisc_pkg;

   // Default datapath and register-index widths.
   localparam int TAM_DEF = 16;
   localparam int RW_DEF  = 3;

   // ULA_ctrl[2:0] operation codes.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   // ULA_ctrl[3]: rotate (1) or shift (0).
   localparam int CMD_ROT = 3;

   // Positions inside the {minus, zero, carry} flag vector.
   localparam int FLG_MINUS = 2;
   localparam int FLG_ZERO  = 1;
   localparam int FLG_CARRY = 0;

endpackage

// File: rtl/nrisc_pipe_slot.sv
// Generic pipeline slot: a valid bit plus a payload register.
// Load has priority over drop, so a slot that empties and refills on the
// same edge stays valid with the new payload. The payload only changes on
// load, which keeps it stable while the slot is held.
module nrisc_pipe_slot #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_drop,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Valid/payload update: load wins, otherwise drop clears valid only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block order.
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_drop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/nrisc_ula_stage.sv
// Two-register execute stage around the combinational NRISC ULA.
//   S0 holds the accepted op and drives the ULA; S1 captures the ULA
//   result/flags for writeback. The stage owns the architectural flags.
// Optional build macro: NRISC_ULA_FWD_EN enables operand forwarding from
// S0 (ULA_OUT) and S1 (out_data) at accept time.
module nrisc_ula_stage
   import nrisc_pkg::*;
#(
   parameter int TAM = TAM_DEF,
   parameter int RW  = RW_DEF
)(
   input  logic           clk,
   input  logic           rst,
   // upstream
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     in_op,
   input  logic           in_incdec,
   input  logic           in_cmp2,
   input  logic [TAM-1:0] in_a,
   input  logic [TAM-1:0] in_b,
   input  logic [RW-1:0]  in_rs_a,
   input  logic [RW-1:0]  in_rs_b,
   input  logic [RW-1:0]  in_rd,
   input  logic           in_rd_we,
   input  logic           in_flag_we,
   // ULA
   output logic [TAM-1:0] ULA_A,
   output logic [TAM-1:0] ULA_B,
   output logic [3:0]     ULA_ctrl,
   output logic           incdec,
   output logic           cmp2,
   input  logic [TAM-1:0] ULA_OUT,
   input  logic [2:0]     ULA_flags,
   // writeback
   output logic           out_valid,
   input  logic           out_ready,
   output logic [TAM-1:0] out_data,
   output logic [RW-1:0]  out_rd,
   output logic           out_rd_we,
   output logic [2:0]     out_flags,
   output logic           out_err,
   output logic [2:0]     flags_q
);

   localparam int S0_W = 4 + 3 + 2*TAM + RW + 2;
   localparam int S1_W = TAM + 3 + RW + 2;

   logic            w_s0_valid, w_s1_valid;
   logic            w_s1_free, w_accept, w_adv;
   logic [S0_W-1:0] w_s0_d, w_s0_q;
   logic [S1_W-1:0] w_s1_d, w_s1_q;

   logic [3:0]      w_s0_op;
   logic            w_s0_incdec, w_s0_cmp2, w_s0_err;
   logic [TAM-1:0]  w_s0_a, w_s0_b;
   logic [RW-1:0]   w_s0_rd;
   logic            w_s0_rd_we, w_s0_flag_we;

   logic [TAM-1:0]  w_opa, w_opb;
   logic            w_err, w_cmp2_ok;
   logic [2:0]      r_flags;

   // Handshake: S1 frees when empty or popping; S0 frees when it can advance.
   assign w_s1_free = ~w_s1_valid | out_ready;
   assign in_ready  = ~w_s0_valid | w_s1_free;
   assign w_accept  = in_valid & in_ready;
   assign w_adv     = w_s0_valid & w_s1_free;

   // incdec together with cmp2 is illegal: keep the increment, drop cmp2.
   assign w_err     = in_incdec & in_cmp2;
   assign w_cmp2_ok = in_cmp2 & ~in_incdec;

`ifdef NRISC_ULA_FWD_EN
   // Operand A: youngest in-flight writer of rs_a wins (S0 before S1).
   always_comb begin
      w_opa = in_a;
      if (w_s0_valid && w_s0_rd_we && (w_s0_rd == in_rs_a))
         w_opa = ULA_OUT;
      else if (w_s1_valid && out_rd_we && (out_rd == in_rs_a))
         w_opa = out_data;
   end

   // Operand B: same priority, resolved independently of A.
   always_comb begin
      w_opb = in_b;
      if (w_s0_valid && w_s0_rd_we && (w_s0_rd == in_rs_b))
         w_opb = ULA_OUT;
      else if (w_s1_valid && out_rd_we && (out_rd == in_rs_b))
         w_opb = out_data;
   end
`else
   assign w_opa = in_a;
   assign w_opb = in_b;
   logic w_unused_rs;
   assign w_unused_rs = ^{in_rs_a, in_rs_b};
`endif

   assign w_s0_d = {in_op, in_incdec, w_cmp2_ok, w_err, w_opa, w_opb,
                    in_rd, in_rd_we, in_flag_we};
   assign {w_s0_op, w_s0_incdec, w_s0_cmp2, w_s0_err, w_s0_a, w_s0_b,
           w_s0_rd, w_s0_rd_we, w_s0_flag_we} = w_s0_q;

   nrisc_pipe_slot #(.W(S0_W)) u_s0 (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_drop  (w_adv),
      .i_data  (w_s0_d),
      .o_valid (w_s0_valid),
      .o_data  (w_s0_q)
   );

   assign w_s1_d = {ULA_OUT, ULA_flags, w_s0_rd, w_s0_rd_we, w_s0_err};
   assign {out_data, out_flags, out_rd, out_rd_we, out_err} = w_s1_q;

   nrisc_pipe_slot #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_adv),
      .i_drop  (out_ready),
      .i_data  (w_s1_d),
      .o_valid (w_s1_valid),
      .o_data  (w_s1_q)
   );

   assign out_valid = w_s1_valid;

   // ULA drive: S0 contents when valid, otherwise held quiet at zero.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      ULA_A    = '0;
      ULA_B    = '0;
      ULA_ctrl = '0;
      incdec   = 1'b0;
      cmp2     = 1'b0;
      if (w_s0_valid) begin
         ULA_A    = w_s0_a;
         ULA_B    = w_s0_b;
         ULA_ctrl = w_s0_op;
         incdec   = w_s0_incdec;
         cmp2     = w_s0_cmp2;
      end
   end

   // Architectural flags follow the op as it moves from S0 into S1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_flags <= 3'b000;
      else if (w_adv && w_s0_flag_we)
         r_flags <= ULA_flags;
   end

   assign flags_q = r_flags;

endmodule

// File: doc/nrisc_ula_stage.md
Name: nrisc_ula_stage

Overview:
Two-register execute stage wrapped around the combinational NRISC ULA (16-bit ALU).
- S0 holds the accepted operation and drives the ULA inputs.
- S1 captures the ULA result and flags, and presents them to writeback.
- The stage owns the architectural flag register {minus, zero, carry}.
- It sits between the decode/register-read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
TAM, 16, datapath width in bits (matches ULA TAM).
RW, 3, register index width (8 GPRs).

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept this cycle
in_op  in  4  ULA_ctrl code: bit3 = rotate(1)/shift(0); bits2:0: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shr, 110 shl, 111 not
in_incdec  in  1  force B = 1
in_cmp2  in  1  force A = all-ones
in_a  in  TAM  operand A from register read
in_b  in  TAM  operand B from register read
in_rs_a  in  RW  source index of A (used only with forwarding)
in_rs_b  in  RW  source index of B (used only with forwarding)
in_rd  in  RW  destination index
in_rd_we  in  1  result is written back
in_flag_we  in  1  update flag register
ULA_A  out  TAM  to ULA input A
ULA_B  out  TAM  to ULA input B
ULA_ctrl  out  4  to ULA control
incdec  out  1  to ULA
cmp2  out  1  to ULA
ULA_OUT  in  TAM  from ULA result
ULA_flags  in  3  from ULA {minus, zero, carry}
out_valid  out  1  S1 result valid
out_ready  in  1  writeback accepts
out_data  out  TAM  registered result
out_rd  out  RW  registered destination
out_rd_we  out  1  registered write enable
out_flags  out  3  registered ULA flags of this op
out_err  out  1  op had illegal incdec&cmp2 combination
flags_q  out  3  architectural flag register {minus, zero, carry}

Behaviour:
- Reset (async, any time):
  - s0_valid = s1_valid = 0; all data/control registers = 0; flags_q = 3'b000.
  - In-flight ops are discarded.
- s1_free = ~s1_valid | out_ready.
- in_ready = ~s0_valid | s1_free (combinational; no dependence on in_valid).
- Accept on in_valid & in_ready: S0 loads op, operands, indices and enables; s0_valid <= 1.
- S0 -> S1 on s0_valid & s1_free:
  - S1 loads ULA_OUT, ULA_flags, s0_rd, s0_rd_we and s0_err.
  - If s0_flag_we is set, flags_q <= ULA_flags on the same edge.
  - If S0 advances with no new accept, s0_valid <= 0.
- S1 drops on out_ready with no S0 advance.
- Simultaneous accept, advance and pop all occur in the same cycle; sustained throughput is 1 op/cycle.
- Latency: accept edge N -> out_valid high after edge N+1 when not stalled.
- ULA drive:
  - With s0_valid = 1: ULA_A/B/ctrl/incdec/cmp2 come from S0.
  - With s0_valid = 0: all are driven 0 (quiet). The ULA active-low reset is tied high at top level, not by this stage.
- Illegal op (in_incdec & in_cmp2 at accept): S0 stores cmp2 = 0 and err = 1; the op completes normally with B = 1 and out_err = 1 for that result.
- Backpressure (out_ready = 0 with s1_valid = 1):
  - S1 holds.
  - S0 holds, and its ULA inputs stay stable.
  - in_ready = ~s0_valid.
- out_* fields are stable while out_valid & ~out_ready.

Optional Feature:
NRISC_ULA_FWD_EN:
- Defined: operand forwarding at accept, evaluated separately for A (in_rs_a) and B (in_rs_b). Priority, highest first:
  - S0 valid & s0_rd_we & s0_rd == rs: use ULA_OUT (S0 always advances when an accept happens).
  - Else S1 valid & out_rd_we & out_rd == rs: use out_data.
  - Else use in_a / in_b.
- Undefined: in_rs_a and in_rs_b are ignored; operands come straight from in_a / in_b.

Decomposition:
- Shared package nrisc_pkg holds:
  - TAM and RW defaults.
  - Op code constants (OP_ADD 3'b000 … OP_NOT 3'b111, CMD_ROT bit 3).
  - Flag bit positions FLG_MINUS = 2, FLG_ZERO = 1, FLG_CARRY = 0.
- One sub-module is natural: nrisc_pipe_slot, a generic valid/hold register slot instantiated for S0 and S1.

Test Plan:
- Add 0x0003 + 0x0004, flag_we = 1, out_ready = 1 -> out_data 0x0007, out_flags 000 one cycle after the accept edge; flags_q 000.
- Sub 0x0005 - 0x0005, flag_we = 1 -> out_data 0x0000, out_flags 010, flags_q 010; a following op with flag_we = 0 leaves flags_q 010.
- Back-to-back stream of 4 ops with out_ready held 0 for 3 cycles -> in_ready goes 0 after 2 accepts, no op lost or duplicated, order preserved, out_data stable while stalled.
- incdec = 1 and cmp2 = 1 on add, A = 0x1234 -> out_err = 1, out_data 0x1235.
- rst asserted mid-stream with both stages full -> out_valid and in_ready reflect an empty pipe immediately, flags_q = 000, no result emitted after release.
- With NRISC_ULA_FWD_EN: op1 add r1 = 0x0001 + 0x0001 immediately followed by op2 add rs_a = r1, in_a = 0xDEAD, B = 0x0002 -> op2 out_data 0x0004. Without the macro, the same sequence gives op2 out_data 0xDEAF.
